// File: rtl/mips_cpu_harvard_dmem_bridge_if.sv
// Memory-side req/ack bus between the harvard CPU data bridge and a multi-cycle data memory.
// The bridge drives the request fields; the memory returns read data with a one-cycle ack strobe.
interface mips_cpu_harvard_dmem_bridge_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mips_cpu_harvard_dmem_bridge.sv
// Converts the CPU's single-cycle data port into a req/ack memory handshake, stalling the core
// through clk_enable while an access is outstanding, with timeout and a sticky bus error.
module mips_cpu_harvard_dmem_bridge #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic        bus_error,
    mips_cpu_harvard_dmem_bridge_if.master mem
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [TW-1:0]         timer;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;

    logic access;
    logic out_of_range;
    logic misaligned;
    logic conflict;
    logic timer_expired;

    assign access        = data_read | data_write;
    assign out_of_range  = |data_address[31:ADDR_WIDTH+2];
    assign misaligned    = |data_address[1:0];
    assign conflict      = data_read & data_write;
    assign timer_expired = (timer == TIMER_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (access) state_next = out_of_range ? DONE : REQ;
            REQ:  if (mem.mem_ack || timer_expired) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The core is stalled from the cycle a request appears until the DONE cycle retires it.
    always_comb begin
        clk_enable  = 1'b1;
        mem.mem_req = 1'b0;
        case (state)
            IDLE: clk_enable = !access;
            REQ: begin
                clk_enable  = 1'b0;
                mem.mem_req = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer         <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            data_readdata <= '0;
            bus_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (access) begin
                    mem_addr_q  <= data_address[ADDR_WIDTH+1:2];
                    mem_wdata_q <= data_writedata;
                    mem_we_q    <= data_write;
                    timer       <= '0;
                    if (out_of_range || misaligned || conflict) bus_error <= 1'b1;
                    // Out-of-range reads return zero; out-of-range writes are silently dropped.
                    if (out_of_range && !data_write) data_readdata <= '0;
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        if (!mem_we_q) data_readdata <= mem.mem_rdata;
                    end else if (timer_expired) begin
                        if (!mem_we_q) data_readdata <= ERR_DATA;
                        bus_error <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mips_cpu_harvard_dmem_bridge.sv
// Scoreboard bench for the data-memory bridge: a CPU/memory model predicts each access outcome
// when it is issued and compares it when the bridge releases the core.
module tb_mips_cpu_harvard_dmem_bridge;
    localparam int          ADDR_WIDTH = 8;
    localparam int          TIMEOUT    = 4;
    localparam logic [31:0] ERR_DATA   = 32'hDEADBEEF;
    localparam int          MAX_CYCLES = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_address = '0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_writedata = '0;
    logic [31:0] data_readdata;
    logic        clk_enable;
    logic        bus_error;

    mips_cpu_harvard_dmem_bridge_if #(.ADDR_WIDTH(ADDR_WIDTH)) mem_bus ();

    mips_cpu_harvard_dmem_bridge #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .TIMEOUT   (TIMEOUT),
        .ERR_DATA  (ERR_DATA)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_address  (data_address),
        .data_read     (data_read),
        .data_write    (data_write),
        .data_writedata(data_writedata),
        .data_readdata (data_readdata),
        .clk_enable    (clk_enable),
        .bus_error     (bus_error),
        .mem           (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]           rdata;
        logic                  berr;
        int                    req_cycles;
        int                    low_cycles;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [31:0]           wdata;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rd = '0;
    logic        model_berr = 1'b0;

    // Asserts reset on a falling edge and checks that every output clears without waiting for a clock.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        data_read = 1'b0;
        data_write = 1'b0;
        mem_bus.mem_ack = 1'b0;
        model_rd = '0;
        model_berr = 1'b0;
        #1;
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_we, bus_error, clk_enable} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl: req/we/berr/clk_en=%b expected 0001",
                     {mem_bus.mem_req, mem_bus.mem_we, bus_error, clk_enable});
        end
        checks++;
        if ({mem_bus.mem_addr, mem_bus.mem_wdata, data_readdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected all zero",
                     mem_bus.mem_addr, mem_bus.mem_wdata, data_readdata);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Issues one CPU access at a falling edge in IDLE; ack_on is the REQ cycle in which memory acks (0 = never).
    task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                          input logic [31:0] wdata, input int ack_on, input logic [31:0] rdata);
        exp_t e;
        exp_t got;
        logic in_range;
        logic done;
        logic fields_ok;
        int   req_cnt;
        int   low_cnt;

        in_range = (addr[31:ADDR_WIDTH+2] == '0);
        e.addr   = addr[ADDR_WIDTH+1:2];
        e.we     = wr;
        e.wdata  = wdata;
        e.req_cycles = !in_range ? 0 : (ack_on == 0 ? TIMEOUT : ack_on);
        e.low_cycles = 1 + e.req_cycles;
        if (!in_range) begin
            if (!wr) model_rd = '0;
        end else if (ack_on == 0) begin
            if (!wr) model_rd = ERR_DATA;
            model_berr = 1'b1;
        end else if (!wr) begin
            model_rd = rdata;
        end
        if (!in_range || addr[1:0] != 2'b00 || (rd && wr)) model_berr = 1'b1;
        e.rdata = model_rd;
        e.berr  = model_berr;
        sb.push_back(e);

        data_address   = addr;
        data_read      = rd;
        data_write     = wr;
        data_writedata = wdata;
        #1;
        low_cnt   = clk_enable ? 0 : 1;
        req_cnt   = 0;
        done      = 1'b0;
        fields_ok = 1'b1;
        for (int cyc = 0; cyc < MAX_CYCLES && !done; cyc++) begin
            @(negedge clk);
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = $urandom;
            if (clk_enable) begin
                done = 1'b1;
            end else begin
                low_cnt++;
                if (mem_bus.mem_req) begin
                    req_cnt++;
                    if (mem_bus.mem_addr !== e.addr || mem_bus.mem_we !== e.we ||
                        mem_bus.mem_wdata !== e.wdata) fields_ok = 1'b0;
                    if (req_cnt == ack_on) begin
                        mem_bus.mem_ack   = 1'b1;
                        mem_bus.mem_rdata = rdata;
                    end
                end
            end
        end

        got = sb.pop_front();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL retire_timeout: addr=%h no clk_enable within %0d cycles", addr, MAX_CYCLES);
        end else begin
            checks += 4;
            if (data_readdata !== got.rdata) begin
                errors++;
                $display("FAIL readdata: addr=%h got %h expected %h", addr, data_readdata, got.rdata);
            end
            if (bus_error !== got.berr) begin
                errors++;
                $display("FAIL bus_error: addr=%h got %b expected %b", addr, bus_error, got.berr);
            end
            if (req_cnt != got.req_cycles) begin
                errors++;
                $display("FAIL req_cycles: addr=%h got %0d expected %0d", addr, req_cnt, got.req_cycles);
            end
            if (low_cnt != got.low_cycles) begin
                errors++;
                $display("FAIL stall_cycles: addr=%h got %0d expected %0d", addr, low_cnt, got.low_cycles);
            end
            if (got.req_cycles > 0) begin
                checks++;
                if (!fields_ok) begin
                    errors++;
                    $display("FAIL req_fields: addr=%h last seen addr=%h we=%b wdata=%h expected %h %b %h",
                             addr, mem_bus.mem_addr, mem_bus.mem_we, mem_bus.mem_wdata,
                             got.addr, got.we, got.wdata);
                end
            end
        end
        data_read  = 1'b0;
        data_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (clk_enable !== 1'b1 || mem_bus.mem_req !== 1'b0) begin
                errors++;
                $display("FAIL idle: cycle %0d clk_en=%b req=%b expected 1 0", i, clk_enable, mem_bus.mem_req);
            end
        end
        // Stray acks while idle must not disturb anything.
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        checks++;
        if (data_readdata !== 32'h0 || mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: rdata=%h req=%b expected 0 0", data_readdata, mem_bus.mem_req);
        end
    endtask

    task automatic test_read_zero_wait();
        access(32'h0000_0010, 1'b1, 1'b0, 32'h0, 1, 32'h1234_5678);
    endtask

    task automatic test_write_wait();
        access(32'h0000_00FC, 1'b0, 1'b1, 32'hCAFE_F00D, 3, 32'hBAD0_BAD0);
    endtask

    task automatic test_back_to_back();
        access(32'h0000_0020, 1'b1, 1'b0, 32'h0, 2, 32'hA5A5_5A5A);
        access(32'h0000_03FC, 1'b1, 1'b0, 32'h0, 1, 32'h0BAD_F00D);
        access(32'h0000_0000, 1'b0, 1'b1, 32'h1357_9BDF, 4, 32'h0);
        access(32'h0000_0204, 1'b1, 1'b0, 32'h0, 3, 32'h2468_ACE0);
    endtask

    task automatic test_timeout();
        access(32'h0000_0040, 1'b1, 1'b0, 32'h0, 0, 32'h0);
        access(32'h0000_0044, 1'b1, 1'b0, 32'h0, 1, 32'h0F0F_0F0F);
        access(32'h0000_0048, 1'b0, 1'b1, 32'h1111_2222, 0, 32'h0);
    endtask

    task automatic test_illegal();
        apply_reset();
        access(32'h0000_0010, 1'b1, 1'b0, 32'h0, 1, 32'h1111_1111);
        access(32'h0000_0400, 1'b1, 1'b0, 32'h0, 1, 32'h9999_9999);
        apply_reset();
        access(32'h0000_0006, 1'b0, 1'b1, 32'h600D_600D, 1, 32'h0);
        apply_reset();
        access(32'h0000_0008, 1'b1, 1'b0, 32'h0, 2, 32'h3333_4444);
        access(32'h0000_000C, 1'b1, 1'b1, 32'h7777_8888, 1, 32'hEEEE_EEEE);
        apply_reset();
        access(32'h8000_0000, 1'b0, 1'b1, 32'hFFFF_0000, 1, 32'h0);
    endtask

    task automatic test_reset_mid_req();
        access(32'h0000_0014, 1'b1, 1'b0, 32'h0, 1, 32'hC0DE_C0DE);
        data_address = 32'h0000_0030;
        data_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_req_setup: req=%b expected 1", mem_bus.mem_req);
        end
        reset = 1'b0;
        data_read = 1'b0;
        model_rd = '0;
        model_berr = 1'b0;
        #1;
        checks++;
        if ({mem_bus.mem_req, clk_enable, bus_error} !== 3'b010 || data_readdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_req_reset: req/clk_en/berr=%b rdata=%h expected 010 0",
                     {mem_bus.mem_req, clk_enable, bus_error}, data_readdata);
        end
        @(negedge clk);
        reset = 1'b1;
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'h0000_0077;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        checks++;
        if (mem_bus.mem_req !== 1'b0 || clk_enable !== 1'b1 || data_readdata !== 32'h0) begin
            errors++;
            $display("FAIL late_ack: req=%b clk_en=%b rdata=%h expected 0 1 0",
                     mem_bus.mem_req, clk_enable, data_readdata);
        end
        @(negedge clk);
        access(32'h0000_0018, 1'b1, 1'b0, 32'h0, 1, 32'h4242_4242);
    endtask

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_cpu_harvard_dmem_bridge.md
Name: mips_cpu_harvard_dmem_bridge

Overview:
Sits directly downstream of the harvard CPU data port (data_address/data_read/data_write/data_writedata/data_readdata) and converts its single-cycle combinational access model into a req/ack handshake to a multi-cycle data memory. Drives the CPU's clk_enable low to stall the core while an access is outstanding, returns registered read data, and enforces a timeout with a sticky bus error. Replaces the zero-latency behavioural RAM used for early CPU bring-up.

Parameters:
ADDR_WIDTH, 8, word-address width on memory side; valid byte range 0 .. 4*2^ADDR_WIDTH-1
TIMEOUT, 16, max REQ cycles waiting for mem_ack before abort (>=1)
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
data_address  input  32  CPU byte address
data_read  input  1  CPU read request
data_write  input  1  CPU write request
data_writedata  input  32  CPU write data
data_readdata  output  32  read data to CPU
clk_enable  output  1  CPU clock enable; 0 = stall core
mem_req  output  1  memory request, held until ack/timeout
mem_we  output  1  1 = write, valid with mem_req
mem_addr  output  ADDR_WIDTH  word address (latched data_address[ADDR_WIDTH+1:2])
mem_wdata  output  32  latched write data
mem_rdata  input  32  memory read data, valid with mem_ack
mem_ack  input  1  single-cycle completion strobe
bus_error  output  1  sticky error flag

Behaviour:
- Reset (reset=0, async): state IDLE, clk_enable=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_readdata=0, bus_error=0, timer=0. Mid-REQ reset drops mem_req immediately; any later mem_ack is ignored.
- States IDLE, REQ, DONE.
- IDLE: clk_enable = !(data_read|data_write) (combinational). On posedge with request: latch word addr, wdata, we=data_write; timer=0; in-range -> REQ, out-of-range -> DONE.
- Out of range: data_address[31:ADDR_WIDTH+2] != 0. No mem_req issued; bus_error set; read returns 0; write dropped.
- Misaligned (data_address[1:0] != 0): bus_error set; access proceeds with bits [1:0] ignored.
- data_read & data_write both high: bus_error set; treated as write.
- REQ: clk_enable=0, mem_req=1. mem_addr/mem_we/mem_wdata stable.
  - posedge with mem_ack: if read, data_readdata<=mem_rdata; -> DONE.
  - no ack and timer==TIMEOUT-1: data_readdata<=ERR_DATA if read, bus_error set, -> DONE (mem_req drops).
  - otherwise timer++.
- DONE: clk_enable=1, mem_req=0; CPU retires the access on this edge; -> IDLE unconditionally.
- data_readdata is registered and holds its value until the next read completes. Writes leave it unchanged.
- Latency: ack in first REQ cycle gives 3 cycles from request to retire (clk_enable low 2 cycles). Each extra ack-wait cycle adds 1.
- mem_ack outside REQ is ignored. bus_error clears only on reset.
- Timer width $clog2(TIMEOUT+1); no wrap is possible because the abort fires first.

Test Plan:
- Reset: reset=0 mid-sim -> all outputs at reset values immediately; release, no request -> clk_enable=1, mem_req=0 for 10 cycles.
- Read, zero wait: data_read, address 0x00000010; memory acks first REQ cycle with 0x12345678 -> mem_addr=4, mem_we=0, clk_enable low 2 cycles, data_readdata=0x12345678 in DONE, bus_error=0.
- Write, 3-cycle wait: data_write, address 0x000000FC, data 0xCAFEF00D; ack after 3 REQ cycles -> mem_req held 3 cycles, mem_addr=0x3F, mem_we=1, mem_wdata=0xCAFEF00D, data_readdata unchanged, clk_enable low 4 cycles.
- Timeout: TIMEOUT=4, read, never ack -> mem_req high exactly 4 cycles, data_readdata=0xDEADBEEF, bus_error=1 and stays 1 after subsequent good accesses.
- Illegal accesses: read 0x00000400 (ADDR_WIDTH=8) -> no mem_req, data_readdata=0, bus_error=1. Write 0x00000006 -> mem_addr=1, bus_error=1. Read+write together -> mem_we=1.
- Reset mid-REQ: assert reset=0 during the 2nd REQ cycle, then pulse mem_ack after release -> mem_req=0 at once, state IDLE, ack ignored, data_readdata=0.
